// File: rtl/dmem_pkg.sv
// Shared constants and request type for the data-memory arbiter slice.
package dmem_pkg;
  localparam int DMEM_AW    = 6;
  localparam int DMEM_DW    = 32;
  localparam int DMEM_WORDS = 16;

  // One memory access as presented by a requester (CPU LSU or loader).
  typedef struct packed {
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
  } dmem_req_t;

  // Word index of a byte address; the low two bits are ignored by the memory.
  function automatic logic [DMEM_AW-3:0] word_idx(input logic [DMEM_AW-1:0] a);
    return a[DMEM_AW-1:2];
  endfunction
endpackage

// File: rtl/dmem.sv
// 16 x 32-bit single-port data memory: combinational read, write on posedge.
module dmem
  import dmem_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [DMEM_AW-1:0] addr,
  input  logic [DMEM_DW-1:0] wdata,
  output logic [DMEM_DW-1:0] rdata
);
  logic [DMEM_DW-1:0] mem_q [DMEM_WORDS];

  // Word write; the byte offset is dropped.
  always_ff @(posedge clk) begin
    if (we) mem_q[word_idx(addr)] <= wdata;
  end

  assign rdata = mem_q[word_idx(addr)];
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: prio names the favoured port on contention.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       prio_nxt
);
  // Single grant per cycle; last winner becomes lowest priority.
  always_comb begin
    gnt      = 2'b00;
    prio_nxt = prio;
    if (req[0] && (!req[1] || !prio)) begin
      gnt[0]   = 1'b1;
      prio_nxt = 1'b1;
    end else if (req[1]) begin
      gnt[1]   = 1'b1;
      prio_nxt = 1'b0;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the CPU LSU (port 0)
// and a debug/DMA loader (port 1). Reads return one cycle after grant.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW        = DMEM_AW,
  parameter int DW        = DMEM_DW,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          misalign
);
  logic          prio_q, prio_d, prio_nxt;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          misalign_q, misalign_d;
  logic [1:0]    arb_gnt, gnt;
  dmem_req_t     p0, p1, sel;

  rr_arb2 u_arb (
    .req      ({req1, req0}),
    .prio     (prio_q),
    .gnt      (arb_gnt),
    .prio_nxt (prio_nxt)
  );

  // Grant gating during reset, granted-port mux, and return-register next state.
  always_comb begin
    p0  = '{we: we0, addr: addr0, wdata: wdata0};
    p1  = '{we: we1, addr: addr1, wdata: wdata1};
    gnt = rst ? 2'b00 : arb_gnt;
    sel = '0;
    if (gnt[0])      sel = p0;
    else if (gnt[1]) sel = p1;

    mem_addr  = sel.addr;
    mem_we    = sel.we;
    mem_wdata = sel.wdata;

    prio_d     = prio_nxt;
    rvalid0_d  = gnt[0] & ~we0;
    rvalid1_d  = gnt[1] & ~we1;
    rdata0_d   = rvalid0_d ? mem_rdata : rdata0_q;
    rdata1_d   = rvalid1_d ? mem_rdata : rdata1_q;
    misalign_d = (|gnt) & (sel.addr[1:0] != 2'b00);
  end

  // Priority pointer and read-return registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q     <= INIT_PRIO;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      misalign_q <= misalign_d;
    end
  end

  assign gnt0     = gnt[0];
  assign gnt1     = gnt[1];
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign misalign = misalign_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter + dmem with a transaction-level reference model.
module tb_dmem_arbiter;
  logic        clk, rst;
  logic        req0, we0, req1, we1;
  logic [5:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, misalign;
  logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [5:0]  mem_addr;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.AW(6), .DW(32), .INIT_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .misalign(misalign)
  );

  dmem u_mem (
    .clk(clk), .we(mem_we), .addr(mem_addr), .wdata(mem_wdata), .rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: who is favoured, and the memory contents.
  int          m_prio;
  logic [31:0] m_mem [16];
  // Expected and observed per-cycle values.
  logic        e_gnt0, e_gnt1, e_we, e_rv0, e_rv1, e_mis;
  logic [5:0]  e_addr;
  logic [31:0] e_wdata, e_rd0 = '0, e_rd1 = '0;
  logic        o_gnt0, o_gnt1, o_we, o_rv0, o_rv1, o_mis;
  logic [5:0]  o_addr;
  logic [31:0] o_wdata, o_rd0, o_rd1;

  task automatic set0(input logic r, input logic w, input logic [5:0] a, input logic [31:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask
  task automatic set1(input logic r, input logic w, input logic [5:0] a, input logic [31:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  // One clock: inputs already driven at negedge; model predicts, DUT sampled.
  task automatic cyc();
    int winner;
    logic [5:0] a;
    #1;
    winner = -1;
    if (!rst) begin
      if (req0 && req1) winner = m_prio;
      else if (req0)    winner = 0;
      else if (req1)    winner = 1;
    end
    e_gnt0  = (winner == 0);
    e_gnt1  = (winner == 1);
    e_we    = (winner == 0) ? we0 : (winner == 1) ? we1 : 1'b0;
    e_addr  = (winner == 0) ? addr0 : (winner == 1) ? addr1 : 6'h00;
    e_wdata = (winner == 0) ? wdata0 : wdata1;
    o_gnt0 = gnt0; o_gnt1 = gnt1; o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata;
    @(posedge clk);
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_mis = 1'b0;
    if (rst) begin
      m_prio = 0; e_rd0 = '0; e_rd1 = '0;
    end else if (winner >= 0) begin
      a = e_addr;
      if (e_we) m_mem[a[5:2]] = e_wdata;
      else if (winner == 0) begin e_rv0 = 1'b1; e_rd0 = m_mem[a[5:2]]; end
      else begin e_rv1 = 1'b1; e_rd1 = m_mem[a[5:2]]; end
      e_mis  = (a[1:0] != 2'b00);
      m_prio = 1 - winner;
    end
    @(negedge clk);
    o_rv0 = rvalid0; o_rv1 = rvalid1; o_rd0 = rdata0; o_rd1 = rdata1; o_mis = misalign;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set0(1'b1, 1'b1, 6'h00, 32'hDEAD_0000);
    set1(1'b1, 1'b1, 6'h04, 32'hDEAD_0001);
    for (int i = 0; i < 2; i++) begin
      cyc();
      total++;
      if ({o_gnt0, o_gnt1, o_we} !== 3'b000) begin
        bad++; $display("FAIL reset_gnt: got gnt0/gnt1/we=%b want 000", {o_gnt0, o_gnt1, o_we});
      end
    end
    total++;
    if ({o_rv0, o_rv1, o_mis, o_rd0, o_rd1} !== '0) begin
      bad++; $display("FAIL reset_regs: rv0=%b rv1=%b mis=%b rd0=%h rd1=%h want all 0",
                      o_rv0, o_rv1, o_mis, o_rd0, o_rd1);
    end
    rst = 1'b0;
    set0(1'b0, 1'b0, 6'h00, 32'h0);
    set1(1'b0, 1'b0, 6'h00, 32'h0);
  endtask

  task automatic test_solo();
    set0(1'b1, 1'b1, 6'h08, 32'h1234_5678);
    cyc();
    total++;
    if ({o_gnt0, o_gnt1, o_we, o_addr, o_rv0} !== {3'b101, 6'h08, 1'b0}) begin
      bad++; $display("FAIL solo_write: gnt0=%b gnt1=%b we=%b addr=%h rv0=%b want 1 0 1 08 0",
                      o_gnt0, o_gnt1, o_we, o_addr, o_rv0);
    end
    set0(1'b1, 1'b0, 6'h08, 32'h0);
    cyc();
    total++;
    if ({o_gnt0, o_gnt1, o_rv0, o_rv1} !== 4'b1010 || o_rd0 !== 32'h1234_5678) begin
      bad++; $display("FAIL solo_read: gnt0=%b gnt1=%b rv0=%b rv1=%b rd0=%h want 1 0 1 0 12345678",
                      o_gnt0, o_gnt1, o_rv0, o_rv1, o_rd0);
    end
    set0(1'b0, 1'b0, 6'h00, 32'h0);
    cyc();
    total++;
    if (o_rv0 !== 1'b0 || o_rd0 !== 32'h1234_5678) begin
      bad++; $display("FAIL solo_hold: rv0=%b rd0=%h want 0 12345678", o_rv0, o_rd0);
    end
  endtask

  // Give every word a known value through port 1 so later reads are defined.
  task automatic test_fill();
    for (int w = 0; w < 16; w++) begin
      set1(1'b1, 1'b1, 6'(w * 4), $urandom);
      cyc();
      total++;
      if ({o_gnt1, o_we, o_addr, o_wdata} !== {e_gnt1, e_we, e_addr, e_wdata} || o_gnt1 !== 1'b1) begin
        bad++; $display("FAIL fill_%0d: gnt1=%b we=%b addr=%h wd=%h want 1 1 %h %h",
                        w, o_gnt1, o_we, o_addr, o_wdata, e_addr, e_wdata);
      end
    end
    set1(1'b0, 1'b0, 6'h00, 32'h0);
  endtask

  task automatic test_contention();
    set0(1'b1, 1'b0, 6'h10, 32'h0);
    set1(1'b1, 1'b0, 6'h20, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      total++;
      if ({o_gnt0, o_gnt1, o_rv0, o_rv1} !== {i % 2 == 0, i % 2 == 1, i % 2 == 0, i % 2 == 1}
          || o_rd0 !== e_rd0 || o_rd1 !== e_rd1) begin
        bad++; $display("FAIL contend_%0d: gnt=%b%b rv=%b%b rd0=%h rd1=%h want rd0=%h rd1=%h",
                        i, o_gnt0, o_gnt1, o_rv0, o_rv1, o_rd0, o_rd1, e_rd0, e_rd1);
      end
    end
    set0(1'b0, 1'b0, 6'h00, 32'h0);
    set1(1'b0, 1'b0, 6'h00, 32'h0);
  endtask

  task automatic test_cross_rw();
    set1(1'b1, 1'b1, 6'h3C, 32'hFFFF_FFFB);
    cyc();
    set1(1'b0, 1'b0, 6'h00, 32'h0);
    set0(1'b1, 1'b0, 6'h3C, 32'h0);
    cyc();
    total++;
    if (o_rv0 !== 1'b1 || o_rd0 !== 32'hFFFF_FFFB || o_rv1 !== 1'b0) begin
      bad++; $display("FAIL cross_rw: rv0=%b rd0=%h rv1=%b want 1 fffffffb 0", o_rv0, o_rd0, o_rv1);
    end
    set0(1'b0, 1'b0, 6'h00, 32'h0);
  endtask

  task automatic test_misalign();
    set0(1'b1, 1'b1, 6'h05, 32'hA5A5_A5A5);
    cyc();
    total++;
    if (o_mis !== 1'b1 || o_rv0 !== 1'b0) begin
      bad++; $display("FAIL misalign_flag: mis=%b rv0=%b want 1 0", o_mis, o_rv0);
    end
    set0(1'b1, 1'b0, 6'h04, 32'h0);
    cyc();
    total++;
    if (o_mis !== 1'b0 || o_rd0 !== 32'hA5A5_A5A5) begin
      bad++; $display("FAIL misalign_data: mis=%b rd0=%h want 0 a5a5a5a5", o_mis, o_rd0);
    end
    set0(1'b0, 1'b0, 6'h00, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] old30;
    old30 = m_mem[12];
    set0(1'b1, 1'b0, 6'h00, 32'h0);   // port 0 wins alone -> port 1 favoured
    cyc();
    rst = 1'b1;
    set0(1'b1, 1'b1, 6'h30, 32'h0BAD_0BAD);
    set1(1'b1, 1'b1, 6'h34, 32'h0BAD_1BAD);
    cyc();
    total++;
    if ({o_gnt0, o_gnt1, o_we} !== 3'b000 || {o_rv0, o_rv1} !== 2'b00 || {o_rd0, o_rd1} !== 64'h0) begin
      bad++; $display("FAIL reset_mid: gnt=%b%b we=%b rv=%b%b rd0=%h rd1=%h want all 0",
                      o_gnt0, o_gnt1, o_we, o_rv0, o_rv1, o_rd0, o_rd1);
    end
    rst = 1'b0;
    set0(1'b1, 1'b0, 6'h30, 32'h0);
    set1(1'b1, 1'b0, 6'h34, 32'h0);
    cyc();
    total++;
    if ({o_gnt0, o_gnt1} !== 2'b10 || o_rd0 !== old30) begin
      bad++; $display("FAIL reset_prio: gnt=%b%b rd0=%h want 10 %h", o_gnt0, o_gnt1, o_rd0, old30);
    end
    set0(1'b0, 1'b0, 6'h00, 32'h0);
    cyc();                              // port 1 served; port 0 favoured again
    total++;
    if ({o_gnt1, o_rv1} !== 2'b11 || o_rd1 !== e_rd1) begin
      bad++; $display("FAIL reset_p1: gnt1=%b rv1=%b rd1=%h want 1 1 %h", o_gnt1, o_rv1, o_rd1, e_rd1);
    end
    set1(1'b0, 1'b0, 6'h00, 32'h0);
  endtask

  task automatic test_withdraw();
    logic any_g1, any_rv1;
    set0(1'b1, 1'b0, 6'h08, 32'h0);
    set1(1'b1, 1'b0, 6'h0C, 32'h0);
    cyc();
    any_g1 = o_gnt1;
    total++;
    if (o_gnt0 !== 1'b1) begin
      bad++; $display("FAIL withdraw_win: gnt0=%b want 1", o_gnt0);
    end
    set0(1'b0, 1'b0, 6'h00, 32'h0);
    set1(1'b0, 1'b0, 6'h00, 32'h0);
    any_rv1 = o_rv1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      any_g1 |= o_gnt1; any_rv1 |= o_rv1;
    end
    total++;
    if ({any_g1, any_rv1} !== 2'b00) begin
      bad++; $display("FAIL withdraw_p1: gnt1 seen=%b rv1 seen=%b want 0 0", any_g1, any_rv1);
    end
    set0(1'b1, 1'b0, 6'h08, 32'h0);
    set1(1'b1, 1'b0, 6'h0C, 32'h0);
    cyc();
    total++;
    if ({o_gnt0, o_gnt1} !== 2'b01) begin
      bad++; $display("FAIL withdraw_prio: gnt=%b%b want 01", o_gnt0, o_gnt1);
    end
    set0(1'b0, 1'b0, 6'h00, 32'h0);
    set1(1'b0, 1'b0, 6'h00, 32'h0);
    cyc();
  endtask

  // Random traffic; an ungranted request keeps its fields or is withdrawn.
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!(req0 && !e_gnt0) || $urandom_range(9) == 0)
        set0($urandom_range(1) == 1, $urandom_range(1) == 1, 6'($urandom), $urandom);
      if (!(req1 && !e_gnt1) || $urandom_range(9) == 0)
        set1($urandom_range(1) == 1, $urandom_range(1) == 1, 6'($urandom), $urandom);
      cyc();
      total++;
      if ({o_gnt0, o_gnt1, o_we, o_addr, o_rv0, o_rv1, o_mis, o_rd0, o_rd1} !==
          {e_gnt0, e_gnt1, e_we, e_addr, e_rv0, e_rv1, e_mis, e_rd0, e_rd1}
          || (e_we && o_wdata !== e_wdata)) begin
        bad++; $display("FAIL random_%0d: gnt=%b%b we=%b addr=%h rv=%b%b mis=%b rd0=%h rd1=%h wd=%h want gnt=%b%b we=%b addr=%h rv=%b%b mis=%b rd0=%h rd1=%h wd=%h",
                        i, o_gnt0, o_gnt1, o_we, o_addr, o_rv0, o_rv1, o_mis, o_rd0, o_rd1, o_wdata,
                        e_gnt0, e_gnt1, e_we, e_addr, e_rv0, e_rv1, e_mis, e_rd0, e_rd1, e_wdata);
      end
    end
    set0(1'b0, 1'b0, 6'h00, 32'h0);
    set1(1'b0, 1'b0, 6'h00, 32'h0);
    cyc();
  endtask

  initial begin
    m_prio = 0;
    foreach (m_mem[i]) m_mem[i] = '0;
    e_gnt0 = 1'b0; e_gnt1 = 1'b0;
    test_reset();
    test_solo();
    test_fill();
    test_contention();
    test_cross_rw();
    test_misalign();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter in front of the single-port data memory (16 x 32-bit words, byte address [5:0], combinational read, write on posedge clk).
- Lets the CPU load/store unit (port 0) and a debug/DMA loader (port 1) share the memory.
- Each requester uses a req/gnt handshake. Read data returns one cycle after grant, with rvalid.
- Also flags misaligned accesses.

Parameters:
- AW, 6, byte address width (word index = addr[AW-1:2]).
- DW, 32, data width.
- INIT_PRIO, 0, requester favoured on the first contention after reset (0 or 1).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- req0  in  1  port 0 request; held with its fields stable until gnt0.
- we0  in  1  port 0 write enable (1 = store, 0 = load).
- addr0  in  AW  port 0 byte address.
- wdata0  in  DW  port 0 write data (signed).
- gnt0  out  1  port 0 accepted this cycle (combinational).
- rvalid0  out  1  port 0 read data valid (registered).
- rdata0  out  DW  port 0 read data (registered).
- req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1: same as port 0, for port 1.
- mem_addr  out  AW  to memory addr.
- mem_we  out  1  to memory write enable.
- mem_wdata  out  DW  to memory wdata.
- mem_rdata  in  DW  from memory rdata.
- misalign  out  1  registered pulse: the access granted last cycle had addr[1:0] != 0.

Behaviour:
- Reset (rst=1 at posedge): prio <= INIT_PRIO; rvalid0=rvalid1=0; rdata0=rdata1=0; misalign=0. While rst=1: gnt0=gnt1=0 and mem_we=0. Any request pending during reset is dropped, and the requester must re-present it.
- Arbitration (combinational, one grant per cycle):
  - only req0: gnt0=1.
  - only req1: gnt1=1.
  - both: the port equal to prio wins.
  - neither: no grant, mem_we=0, mem_addr=0.
- Priority pointer: after any grant to port k, prio <= ~k (last winner becomes lowest priority). No grant leaves prio unchanged.
- Memory mux:
  - mem_addr, mem_we and mem_wdata come from the granted port. mem_we = granted & we_k.
  - The write lands at the same posedge as the grant. The memory ignores addr[1:0], so the word index is addr[5:2].
- Read return:
  - If the granted access has we_k=0: rdata_k <= mem_rdata and rvalid_k <= 1 at that posedge. Latency is 1 cycle from gnt to rvalid.
  - rvalid_k is a single-cycle pulse; rdata_k holds its value until the next read to that port.
  - Writes never assert rvalid.
- Back-to-back: a port granted on consecutive cycles gets rvalid on consecutive cycles. The other port gets no rvalid.
- Read-after-write:
  - Same address, write granted in cycle N, read granted in N+1: the read returns the new data.
  - Same-cycle conflicts cannot occur (single grant).
- misalign <= granted & (addr_k[1:0] != 0). The access still proceeds, word-aligned.
- Starvation bound: under continuous contention, grants alternate, so each port waits at most 1 cycle.
- Protocol violation: a requester dropping req before gnt is legal, and the request is simply withdrawn. Changing fields while req is held without gnt is undefined.

Decomposition:
- Shared package (dmem_pkg) holds constants DMEM_AW=6, DMEM_DW=32, DMEM_WORDS=16.
- Shared package also holds a request struct/typedef {we, addr, wdata}, reused by the CPU and loader.
- Sub-module rr_arb2: combinational 2-way round-robin grant from req[1:0] and prio, plus the next-prio output.
- Datapath mux and return registers stay in dmem_arbiter.
- Bench instantiates dmem_arbiter with dmem.

Test Plan:
- Reset then solo access: rst 2 cycles; port 0 writes 32'h1234_5678 to addr 6'h08; next cycle reads 6'h08 -> gnt0 both cycles, rvalid0 in the cycle after the read grant, rdata0=32'h1234_5678, gnt1=0 throughout.
- Contention alternation: req0 and req1 held 6 cycles, both reads, INIT_PRIO=0 -> grants 0,1,0,1,0,1; each rvalid follows its grant by 1 cycle; prio ends at 0.
- Write-then-read across ports: port 1 writes -32'sd5 to 6'h3C; port 0 reads 6'h3C the next cycle -> rdata0=32'hFFFF_FFFB.
- Misalign: port 0 writes 32'hA5A5_A5A5 to 6'h05 -> misalign=1 one cycle later; word 1 (6'h04) reads back 32'hA5A5_A5A5.
- Reset mid-operation: both requesting, assert rst during a cycle with prio=1 -> gnt0=gnt1=0, no memory write; after release prio=INIT_PRIO, so port 0 wins the first contention; rvalid0/1=0 and rdata0/1=0.
- Idle/withdraw: req1 asserted and dropped in the same cycle that port 0 wins -> gnt1 never asserts, no rvalid1, prio=1 afterwards.
